// File: rtl/ll_ccie_pkg.sv
// Shared definitions for the ll_ccie read/write buffers: the read-buffer
// state encoding and the line geometry.
package ll_ccie_pkg;

  localparam int CCIE_CACHE_WIDTH = 512;
  localparam int CCIE_DATA_WIDTH  = 32;
  localparam int WORDS_PER_LINE   = CCIE_CACHE_WIDTH / CCIE_DATA_WIDTH;
  localparam int WORD_OFF_W       = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    RB_IDLE   = 2'd0,
    RB_LOOKUP = 2'd1,
    RB_REQ    = 2'd2,
    RB_WAIT   = 2'd3
  } rb_state_t;

endpackage

// File: rtl/read_buffer.sv
// One-line read cache between the core's word read port and the ll_ccie
// read request/response channels. Hits return in one cycle; a miss fetches
// the whole line with a single tagged request and returns the word one
// cycle after the matching response.
module read_buffer
  import ll_ccie_pkg::*;
#(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [ADDR_LMT-1:0]    rd_req_addr,
  output logic [MDATA-1:0]       rd_req_mdata,
  output logic                   rd_req_en,
  input  logic                   rd_req_almostfull,
  input  logic                   rd_rsp_valid,
  input  logic [MDATA-1:0]       rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic                   rd_en,
  input  logic [ADDR_LMT+3:0]    rd_addr,
  input  logic                   invalidate,
  output logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  rb_state_t state_reg, state_next;

  logic                  line_valid_reg;
  logic [ADDR_LMT-1:0]   line_addr_reg;
  logic [DATA_WIDTH-1:0] line_words_reg [WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0] rsp_words      [WORDS_PER_LINE];
  logic [ADDR_LMT-1:0]   miss_line_reg;
  logic [WORD_OFF_W-1:0] miss_off_reg;
  logic [MDATA-1:0]      tag_reg;
  logic                  inv_seen_reg;
  logic                  rd_valid_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;

  logic [ADDR_LMT-1:0]   req_line;
  logic [WORD_OFF_W-1:0] req_off;
  logic                  hit;
  logic                  rsp_match;
  logic                  ready_c;
  logic                  req_en_c;

  assign req_line = rd_addr[ADDR_LMT+3:4];
  assign req_off  = rd_addr[3:0];

  // A coincident invalidate forces a miss, so the freshly written data is refetched.
  assign hit       = line_valid_reg && !invalidate && (line_addr_reg == req_line);
  assign rsp_match = (state_reg == RB_WAIT) && rd_rsp_valid && (rd_rsp_mdata == tag_reg);

  // Split the response line into words so both the fill and the bypass use plain indexing.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_words
      assign rsp_words[gi] = rd_rsp_data[gi*DATA_WIDTH +: DATA_WIDTH];

      // Line storage: written only on a matching fill, never reset.
      always_ff @(posedge clk) begin
        if (rsp_match) begin
          line_words_reg[gi] <= rsp_words[gi];
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus the combinational handshake outputs.
  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    req_en_c   = 1'b0;
    case (state_reg)
      RB_IDLE: begin
        if (start) state_next = RB_LOOKUP;
      end
      RB_LOOKUP: begin
        ready_c = 1'b1;
        if (rd_en && !hit) state_next = RB_REQ;
      end
      RB_REQ: begin
        if (!rd_req_almostfull) begin
          req_en_c   = 1'b1;
          state_next = RB_WAIT;
        end
      end
      RB_WAIT: begin
        if (rsp_match) state_next = RB_LOOKUP;
      end
      default: state_next = RB_IDLE;
    endcase
  end

  // Datapath: hit returns, miss bookkeeping, fill and tag advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid_reg <= 1'b0;
      line_addr_reg  <= '0;
      miss_line_reg  <= '0;
      miss_off_reg   <= '0;
      tag_reg        <= '0;
      inv_seen_reg   <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
    end else begin
      rd_valid_reg <= 1'b0;
      case (state_reg)
        RB_LOOKUP: begin
          if (invalidate) line_valid_reg <= 1'b0;
          if (rd_en) begin
            if (hit) begin
              rd_valid_reg <= 1'b1;
              rd_data_reg  <= line_words_reg[req_off];
            end else begin
              miss_line_reg <= req_line;
              miss_off_reg  <= req_off;
              inv_seen_reg  <= 1'b0;
            end
          end
        end
        RB_REQ: begin
          if (invalidate) begin
            line_valid_reg <= 1'b0;
            inv_seen_reg   <= 1'b1;
          end
        end
        RB_WAIT: begin
          if (invalidate) begin
            line_valid_reg <= 1'b0;
            inv_seen_reg   <= 1'b1;
          end
          if (rsp_match) begin
            // The word is still returned, but an invalidate seen during the
            // miss means the filled line cannot be trusted for later hits.
            line_addr_reg  <= miss_line_reg;
            line_valid_reg <= !(inv_seen_reg || invalidate);
            tag_reg        <= tag_reg + 1'b1;
            rd_valid_reg   <= 1'b1;
            rd_data_reg    <= rsp_words[miss_off_reg];
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_ready     = ready_c;
  assign rd_req_en    = req_en_c;
  assign rd_req_addr  = miss_line_reg;
  assign rd_req_mdata = tag_reg;
  assign rd_valid     = rd_valid_reg;
  assign rd_data      = rd_data_reg;

endmodule
